fp16_align_add: RTL

FP16_ALIGN_ADD -- requirements
Module: fp16_align_add

---
 rtl/fp16_align_add.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fp16_align_add.sv
// fp16_align_add: aligns two IEEE-754 half-precision operands by shifting
// the smaller-exponent significand right one bit per cycle, then forms the
// signed 14-bit sum for a downstream normalizer. Ready/valid on both sides.
module fp16_align_add (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [13:0] mantisa,
  output logic [4:0]  exp,
  output logic        special
);

  typedef enum logic [1:0] {StIdle, StAlign, StAdd, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [12:0] mag_l_q, mag_l_d;
  logic [12:0] mag_s_q, mag_s_d;
  logic        sign_l_q, sign_l_d;
  logic        sign_s_q, sign_s_d;
  logic        spec_pend_q, spec_pend_d;
  logic [13:0] mantisa_q, mantisa_d;
  logic [4:0]  exp_q, exp_d;
  logic        special_q, special_d;

  // Operand decode: denormals use effective exponent 1 and no hidden bit.
  logic [4:0]  eff_exp_a, eff_exp_b;
  logic [12:0] mag_a, mag_b;
  logic        sign_b_eff;
  logic        a_is_l;
  logic [4:0]  exp_diff;
  logic        any_special;
  logic [13:0] term_l, term_s;

  // Decode incoming operands and ordering information.
  always_comb begin
    eff_exp_a   = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
    eff_exp_b   = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
    // Significand sits at [11:1]; bit 0 is a guard bit, bit 12 headroom.
    mag_a       = {1'b0, (a[14:10] != 5'd0), a[9:0], 1'b0};
    mag_b       = {1'b0, (b[14:10] != 5'd0), b[9:0], 1'b0};
    sign_b_eff  = b[15] ^ op;
    a_is_l      = (eff_exp_a >= eff_exp_b);
    exp_diff    = a_is_l ? (eff_exp_a - eff_exp_b) : (eff_exp_b - eff_exp_a);
    any_special = (&a[14:10]) | (&b[14:10]);
  end

  // Signed terms for the final addition.
  always_comb begin
    term_l = sign_l_q ? (14'd0 - {1'b0, mag_l_q}) : {1'b0, mag_l_q};
    term_s = sign_s_q ? (14'd0 - {1'b0, mag_s_q}) : {1'b0, mag_s_q};
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mag_l_d     = mag_l_q;
    mag_s_d     = mag_s_q;
    sign_l_d    = sign_l_q;
    sign_s_d    = sign_s_q;
    spec_pend_d = spec_pend_q;
    mantisa_d   = mantisa_q;
    exp_d       = exp_q;
    special_d   = special_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          spec_pend_d = any_special;
          if (a_is_l) begin
            mag_l_d  = mag_a;
            sign_l_d = a[15];
            mag_s_d  = mag_b;
            sign_s_d = sign_b_eff;
            exp_d    = eff_exp_a;
          end else begin
            mag_l_d  = mag_b;
            sign_l_d = sign_b_eff;
            mag_s_d  = mag_a;
            sign_s_d = a[15];
            exp_d    = eff_exp_b;
          end
          // Shifting 13 places already clears the 13-bit magnitude.
          if (any_special) begin
            count_d = 4'd0;
          end else if (exp_diff > 5'd13) begin
            count_d = 4'd13;
          end else begin
            count_d = exp_diff[3:0];
          end
          if (!any_special && exp_diff != 5'd0) begin
            state_d = StAlign;
          end else begin
            state_d = StAdd;
          end
        end
      end
      StAlign: begin
        mag_s_d = mag_s_q >> 1;
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = StAdd;
        end
      end
      StAdd: begin
        if (spec_pend_q) begin
          special_d = 1'b1;
          mantisa_d = 14'd0;
          exp_d     = 5'd31;
        end else begin
          special_d = 1'b0;
          mantisa_d = term_l + term_s;
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= 4'd0;
      mag_l_q     <= 13'd0;
      mag_s_q     <= 13'd0;
      sign_l_q    <= 1'b0;
      sign_s_q    <= 1'b0;
      spec_pend_q <= 1'b0;
      mantisa_q   <= 14'd0;
      exp_q       <= 5'd0;
      special_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mag_l_q     <= mag_l_d;
      mag_s_q     <= mag_s_d;
      sign_l_q    <= sign_l_d;
      sign_s_q    <= sign_s_d;
      spec_pend_q <= spec_pend_d;
      mantisa_q   <= mantisa_d;
      exp_q       <= exp_d;
      special_q   <= special_d;
    end
  end

  // Output decode.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    mantisa   = mantisa_q;
    exp       = exp_q;
    special   = special_q;
  end

endmodule
